vector_addsub_pipe: RTL and testbench

- Multi-beat, handshaked vector integer add/subtract unit for the vector processor execute stage.
- Supports SEW 8/16/32, wrapping and saturating (signed/unsigned) modes, per-element masking, and vxsat reporting.
- Processes one LANE_W-bit slice of the VLEN-bit operands per cycle and registers the full result.
- Replaces the single-cycle combinational adder/subtractor in the execute path.

---
 rtl/vector_processor_pkg.sv | 39 +++
 rtl/addsub_lane_slice.sv | 77 +++++++
 rtl/vector_addsub_pipe.sv | 145 ++++++++++++++
 tb/tb_vector_addsub_pipe.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_processor_pkg.sv
// ============================================================================
//  Module      : vector_processor_pkg
//  Description : Shared types and element-count helpers for the vector
//                execute stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef VLEN
`define VLEN 512
`endif

package vector_processor_pkg;

  typedef enum logic [1:0] {
    SEW8  = 2'b00,
    SEW16 = 2'b01,
    SEW32 = 2'b10
  } sew_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } addsub_state_e;

  localparam logic [1:0] C_SEW_ILLEGAL = 2'b11;

  function automatic int elem_bits(logic [1:0] sew);
    return 8 << sew;
  endfunction

  function automatic int elems_per_lane(int lane_w, logic [1:0] sew);
    return lane_w / elem_bits(sew);
  endfunction

endpackage

`default_nettype wire

// File: rtl/addsub_lane_slice.sv
// ============================================================================
//  Module      : addsub_lane_slice
//  Description : One LANE_W-bit slice of element-segmented add/sub with
//                saturation, masking and a slice saturation flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_lane_slice
  import vector_processor_pkg::*;
#(
  parameter int LANE_W = 128
) (
  input  logic                  op_sub_i,
  input  logic                  op_sat_i,
  input  logic                  op_signed_i,
  input  logic [1:0]            sew_i,
  input  logic                  vm_i,
  input  logic                  mask_agn_i,
  input  logic [LANE_W/8-1:0]   mask_i,
  input  logic [LANE_W-1:0]     a_i,
  input  logic [LANE_W-1:0]     b_i,
  input  logic [LANE_W-1:0]     vd_old_i,
  output logic [LANE_W-1:0]     res_o,
  output logic                  sat_o
);

  logic [2:0][LANE_W-1:0] w_res;
  logic [2:0]             w_sat;

  // One fully independent datapath per SEW; the result is picked afterwards.
  for (genvar s = 0; s < 3; s++) begin : g_sew
    localparam int EW = 8 << s;
    localparam int NE = LANE_W / EW;
    logic [NE-1:0] w_elem_sat;

    for (genvar e = 0; e < NE; e++) begin : g_elem
      logic [EW-1:0] w_a, w_bx, w_vd, w_wrap, w_clamp;
      logic [EW:0]   w_sum;
      logic          w_active, w_ovf;

      assign w_a    = a_i[e*EW +: EW];
      assign w_bx   = op_sub_i ? ~b_i[e*EW +: EW] : b_i[e*EW +: EW];
      assign w_vd   = vd_old_i[e*EW +: EW];
      assign w_sum  = {1'b0, w_a} + {1'b0, w_bx} + {{EW{1'b0}}, op_sub_i};
      assign w_wrap = w_sum[EW-1:0];

      // Unsigned: carry-out on add, missing carry (borrow) on sub.
      assign w_ovf = op_signed_i
                   ? ((w_a[EW-1] == w_bx[EW-1]) && (w_wrap[EW-1] != w_a[EW-1]))
                   : (w_sum[EW] ^ op_sub_i);
      assign w_clamp = op_signed_i ? {w_a[EW-1], {(EW-1){~w_a[EW-1]}}}
                                   : {EW{~op_sub_i}};

      assign w_active      = vm_i | mask_i[e];
      assign w_elem_sat[e] = w_active & op_sat_i & w_ovf;
      assign w_res[s][e*EW +: EW] = !w_active     ? (mask_agn_i ? {EW{1'b1}} : w_vd)
                                  : w_elem_sat[e] ? w_clamp : w_wrap;
    end

    assign w_sat[s] = |w_elem_sat;
  end

  always_comb begin
    res_o = vd_old_i;
    sat_o = 1'b0;
    case (sew_i)
      SEW8:    begin res_o = w_res[0]; sat_o = w_sat[0]; end
      SEW16:   begin res_o = w_res[1]; sat_o = w_sat[1]; end
      SEW32:   begin res_o = w_res[2]; sat_o = w_sat[2]; end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/vector_addsub_pipe.sv
// ============================================================================
//  Module      : vector_addsub_pipe
//  Description : Multi-beat handshaked vector add/subtract; one LANE_W slice
//                per cycle into a registered full-width result.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef VLEN
`define VLEN 512
`endif

module vector_addsub_pipe
  import vector_processor_pkg::*;
#(
  parameter int VLEN   = `VLEN,
  parameter int LANE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op_sub,
  input  logic              op_sat,
  input  logic              op_signed,
  input  logic [1:0]        sew,
  input  logic              vm,
  input  logic              mask_agn,
  input  logic [VLEN/8-1:0] mask,
  input  logic [VLEN-1:0]   A,
  input  logic [VLEN-1:0]   B,
  input  logic [VLEN-1:0]   vd_old,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VLEN-1:0]   result,
  output logic              vxsat,
  output logic              err
);

  localparam int NUM_BEATS = VLEN / LANE_W;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int MASK_W    = VLEN / 8;
  localparam int LMASK_W   = LANE_W / 8;
  localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  addsub_state_e       state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                op_sub_q, op_sat_q, op_signed_q, vm_q, mask_agn_q;
  logic [1:0]          sew_q;
  logic [MASK_W-1:0]   mask_q;
  logic [VLEN-1:0]     a_q, b_q, vd_old_q, result_q;
  logic                vxsat_q, err_q;

  logic                w_accept, w_illegal;
  logic [LANE_W-1:0]   w_a_slice, w_b_slice, w_vd_slice, w_res_slice;
  logic [LMASK_W-1:0]  w_mask_slice;
  logic                w_slice_sat;

  assign w_accept  = (state_q == IDLE) && in_valid;
  assign w_illegal = (sew == C_SEW_ILLEGAL);

  assign w_a_slice  = a_q[beat_q*LANE_W +: LANE_W];
  assign w_b_slice  = b_q[beat_q*LANE_W +: LANE_W];
  assign w_vd_slice = vd_old_q[beat_q*LANE_W +: LANE_W];
  // Mask bits are indexed by global element number, so the offset depends on SEW.
  assign w_mask_slice = LMASK_W'(mask_q >> (int'(beat_q) * elems_per_lane(LANE_W, sew_q)));

  addsub_lane_slice #(.LANE_W(LANE_W)) u_slice (
    .op_sub_i    (op_sub_q),
    .op_sat_i    (op_sat_q),
    .op_signed_i (op_signed_q),
    .sew_i       (sew_q),
    .vm_i        (vm_q),
    .mask_agn_i  (mask_agn_q),
    .mask_i      (w_mask_slice),
    .a_i         (w_a_slice),
    .b_i         (w_b_slice),
    .vd_old_i    (w_vd_slice),
    .res_o       (w_res_slice),
    .sat_o       (w_slice_sat)
  );

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: if (in_valid) state_d = w_illegal ? DONE : BUSY;
      BUSY: begin
        beat_d = beat_q + BEAT_W'(1);
        if (beat_q == C_LAST_BEAT) begin
          state_d = DONE;
          beat_d  = '0;
        end
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      result_q <= '0;
      vxsat_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (w_accept) begin
        vxsat_q <= 1'b0;
        err_q   <= w_illegal;
        if (w_illegal) result_q <= vd_old;
      end else if (state_q == BUSY) begin
        result_q[beat_q*LANE_W +: LANE_W] <= w_res_slice;
        vxsat_q <= vxsat_q | w_slice_sat;
      end
    end
  end

  // Operand capture needs no reset: it is always reloaded before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      op_sub_q    <= op_sub;
      op_sat_q    <= op_sat;
      op_signed_q <= op_signed;
      sew_q       <= sew;
      vm_q        <= vm;
      mask_agn_q  <= mask_agn;
      mask_q      <= mask;
      a_q         <= A;
      b_q         <= B;
      vd_old_q    <= vd_old;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign vxsat     = vxsat_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_vector_addsub_pipe.sv
// ============================================================================
//  Module      : tb_vector_addsub_pipe
//  Description : Scoreboard bench for vector_addsub_pipe with an element-level
//                integer reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

`ifndef VLEN
`define VLEN 512
`endif

module tb_vector_addsub_pipe;

  localparam int VLEN = `VLEN;
  localparam int LANE_W = 128;
  localparam int NB = VLEN / LANE_W;
  localparam int MW = VLEN / 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0, in_ready;
  logic            op_sub = 1'b0, op_sat = 1'b0, op_signed = 1'b0;
  logic [1:0]      sew = 2'b00;
  logic            vm = 1'b1, mask_agn = 1'b0;
  logic [MW-1:0]   mask = '0;
  logic [VLEN-1:0] A = '0, B = '0, vd_old = '0;
  logic            out_valid, out_ready = 1'b1;
  logic [VLEN-1:0] result;
  logic            vxsat, err;

  always #5 clk = ~clk;

  vector_addsub_pipe #(.VLEN(VLEN), .LANE_W(LANE_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .op_sat(op_sat), .op_signed(op_signed), .sew(sew),
    .vm(vm), .mask_agn(mask_agn), .mask(mask), .A(A), .B(B), .vd_old(vd_old),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .vxsat(vxsat), .err(err)
  );

  typedef struct {
    bit            sub, sat, sgn;
    bit [1:0]      sew;
    bit            vm, agn;
    bit [MW-1:0]   mask;
    bit [VLEN-1:0] a, b, vd;
  } op_t;

  typedef struct {
    logic [VLEN-1:0] res;
    logic            sat;
    logic            err;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void chk(string name, logic [VLEN-1:0] act, logic [VLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void chk_int(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Reference: each element as a plain integer, clamped to its representable range.
  function automatic exp_t model(op_t o);
    exp_t e;
    int ew, ne;
    longint m, av, bv, vv, r, mn, mx;
    logic [VLEN-1:0] t, piece;
    bit act;
    e.res = '0; e.sat = 1'b0; e.err = 1'b0;
    if (o.sew == 2'b11) begin
      e.res = o.vd; e.err = 1'b1;
      return e;
    end
    ew = 8 << o.sew;
    ne = VLEN / ew;
    m  = (longint'(1) << ew) - 1;
    for (int i = 0; i < ne; i++) begin
      t = o.a >> (i*ew);  av = longint'(t[63:0]) & m;
      t = o.b >> (i*ew);  bv = longint'(t[63:0]) & m;
      t = o.vd >> (i*ew); vv = longint'(t[63:0]) & m;
      if (o.sgn) begin
        if (av >= (longint'(1) << (ew-1))) av -= (longint'(1) << ew);
        if (bv >= (longint'(1) << (ew-1))) bv -= (longint'(1) << ew);
        mn = -(longint'(1) << (ew-1)); mx = (longint'(1) << (ew-1)) - 1;
      end else begin
        mn = 0; mx = m;
      end
      r = o.sub ? av - bv : av + bv;
      act = o.vm || o.mask[i];
      if (o.sat && (r < mn || r > mx)) begin
        r = (r < mn) ? mn : mx;
        if (act) e.sat = 1'b1;
      end
      if (!act) r = o.agn ? m : vv;
      piece = '0;
      piece[63:0] = r & m;
      e.res |= piece << (i*ew);
    end
    return e;
  endfunction

  function automatic op_t mk(bit sub, bit sat, bit sgn, bit [1:0] s, bit v, bit agn);
    op_t o;
    o.sub = sub; o.sat = sat; o.sgn = sgn; o.sew = s; o.vm = v; o.agn = agn;
    o.mask = '0; o.a = '0; o.b = '0; o.vd = '0;
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    o = mk(1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
           ($urandom_range(0,7) == 0) ? 2'b11 : 2'($urandom_range(0,2)),
           1'($urandom_range(0,1)), 1'($urandom_range(0,1)));
    for (int i = 0; i < VLEN/32; i++) begin
      o.a[i*32 +: 32]  = $urandom;
      o.b[i*32 +: 32]  = $urandom;
      o.vd[i*32 +: 32] = $urandom;
    end
    for (int i = 0; i < MW/32; i++) o.mask[i*32 +: 32] = $urandom;
    return o;
  endfunction

  task automatic scramble();
    for (int i = 0; i < VLEN/32; i++) begin
      A[i*32 +: 32] = $urandom; B[i*32 +: 32] = $urandom; vd_old[i*32 +: 32] = $urandom;
    end
    mask = ~mask; op_sub = ~op_sub; op_sat = ~op_sat; vm = ~vm; sew = 2'($urandom);
  endtask

  // Returns #1 after the accepting edge.
  task automatic issue(op_t o, bit push);
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    chk_int("in_ready_wait", int'(in_ready), 1);
    op_sub = o.sub; op_sat = o.sat; op_signed = o.sgn; sew = o.sew;
    vm = o.vm; mask_agn = o.agn; mask = o.mask; A = o.a; B = o.b; vd_old = o.vd;
    in_valid = 1'b1;
    if (push) sb_q.push_back(model(o));
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
  endtask

  // Counts clock edges after the accepting edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
  endtask

  task automatic directed(string name, op_t o, int lat_exp,
                          logic [VLEN-1:0] res_exp, bit sat_exp, bit err_exp);
    int lat;
    issue(o, 1'b1);
    wait_valid(lat);
    chk_int({name, "_latency"}, lat, lat_exp);
    chk({name, "_result"}, result, res_exp);
    chk({name, "_vxsat"}, VLEN'(vxsat), VLEN'(sat_exp));
    chk({name, "_err"}, VLEN'(err), VLEN'(err_exp));
    @(posedge clk); #1;
  endtask

  task automatic run_random(op_t o);
    int  g = 0;
    bit  done = 1'b0;
    issue(o, 1'b1);
    while (!done && g < 60) begin
      out_ready = ($urandom_range(0,3) != 0);
      @(negedge clk);
      if (out_valid && out_ready) done = 1'b1;
      @(posedge clk); #1;
      g++;
    end
    out_ready = 1'b1;
    chk_int("random_handshake", int'(done), 1);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready && !reset) begin
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_unexpected: got output with %0d pending expected %0d", 0, 1);
        end else begin
          e = sb_q.pop_front();
          chk("sb_result", result, e.res);
          chk("sb_vxsat", VLEN'(vxsat), VLEN'(e.sat));
          chk("sb_err", VLEN'(err), VLEN'(e.err));
        end
      end
    end
  endtask

  initial begin
    op_t o;
    int  lat;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", VLEN'(in_ready), VLEN'(1'b1));
    chk("rst_out_valid", VLEN'(out_valid), '0);
    chk("rst_result", result, '0);
    chk("rst_vxsat", VLEN'(vxsat), '0);
    chk("rst_err", VLEN'(err), '0);
    reset = 1'b0;

    o = mk(0, 0, 0, 2'b00, 1, 0);
    o.a = {(VLEN/8){8'h7F}}; o.b = {(VLEN/8){8'h01}};
    directed("wrap8", o, NB, {(VLEN/8){8'h80}}, 1'b0, 1'b0);

    o.sat = 1'b1; o.sgn = 1'b1;
    directed("ssat8", o, NB, {(VLEN/8){8'h7F}}, 1'b1, 1'b0);

    o.vm = 1'b0; o.mask = '0; o.agn = 1'b0; o.vd = {(VLEN/8){8'h55}};
    directed("masked8", o, NB, {(VLEN/8){8'h55}}, 1'b0, 1'b0);

    o = mk(1, 1, 0, 2'b01, 1, 0);
    o.a = {(VLEN/16){16'h0003}}; o.b = {(VLEN/16){16'h0005}};
    directed("usub_sat16", o, NB, '0, 1'b1, 1'b0);
    o.sat = 1'b0;
    directed("usub_wrap16", o, NB, {(VLEN/16){16'hFFFE}}, 1'b0, 1'b0);

    o = mk(0, 0, 0, 2'b10, 0, 1);
    o.a = {(VLEN/32){32'hFFFFFFFF}}; o.b = {(VLEN/32){32'h00000001}};
    o.mask[0] = 1'b1;
    directed("carry32", o, NB, {{(VLEN/32-1){32'hFFFFFFFF}}, 32'h00000000}, 1'b0, 1'b0);

    // Illegal SEW, consumer stalls for five cycles.
    o = mk(0, 0, 0, 2'b11, 1, 0);
    o.vd = {(VLEN/32){32'hA5C3_0F1E}};
    out_ready = 1'b0;
    issue(o, 1'b1);
    wait_valid(lat);
    chk_int("illegal_latency", lat, 0);
    chk("illegal_err", VLEN'(err), VLEN'(1'b1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_result", result, o.vd);
      chk("hold_in_ready", VLEN'(in_ready), '0);
      chk("hold_out_valid", VLEN'(out_valid), VLEN'(1'b1));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("illegal_drained", VLEN'(out_valid), '0);

    // Reset while the third beat is being computed.
    o = mk(0, 0, 0, 2'b00, 1, 0);
    o.a = {(VLEN/8){8'h11}}; o.b = {(VLEN/8){8'h22}};
    issue(o, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", VLEN'(in_ready), VLEN'(1'b1));
    chk("midrst_out_valid", VLEN'(out_valid), '0);
    chk("midrst_result", result, '0);
    directed("after_rst", o, NB, {(VLEN/8){8'h33}}, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) run_random(rnd_op());

    repeat (3) @(posedge clk);
    chk_int("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d tests expected completion", n_tests);
    $fatal(1);
  end

endmodule

`default_nettype wire
